// File: rtl/tnet_debug_reader_if.sv
// Debug snapshot inputs, dump request and the 16-bit dump word stream of tnet_debug_reader.
interface tnet_debug_reader_if;
   logic [4:0]  cmd_st_i;
   logic [99:0] cmd_hist_i;
   logic [7:0]  ready_cnt_i;
   logic [7:0]  error_cnt_i;
   logic [3:0]  error_id_i;
   logic [31:0] error_hist_i;
   logic        req_i;
   logic [15:0] dt_o;
   logic        dt_vld_o;
   logic        dt_rdy_i;
   logic        busy_o;
   logic        done_o;

   modport master (
      output cmd_st_i, cmd_hist_i, ready_cnt_i, error_cnt_i, error_id_i, error_hist_i,
      output req_i, dt_rdy_i,
      input  dt_o, dt_vld_o, busy_o, done_o
   );

   modport slave (
      input  cmd_st_i, cmd_hist_i, ready_cnt_i, error_cnt_i, error_id_i, error_hist_i,
      input  req_i, dt_rdy_i,
      output dt_o, dt_vld_o, busy_o, done_o
   );
endinterface

// File: rtl/tnet_debug_reader.sv
// Snapshots command/error debug state on request and streams it out as a
// header, optional history sections and a trailer over a valid/ready link.
module tnet_debug_reader #(
   parameter int unsigned DEBUG = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   tnet_debug_reader_if.slave  bus
);

   localparam int unsigned WORD_W = 16;
   localparam int unsigned CMD_N  = 20;
   localparam int unsigned ERR_N  = 8;

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] HDR0 = 3'd1;
   localparam logic [2:0] HDR1 = 3'd2;
   localparam logic [2:0] CMD  = 3'd3;
   localparam logic [2:0] ERR  = 3'd4;
   localparam logic [2:0] TRL  = 3'd5;

   logic [2:0]        state,           state_nx;
   logic [4:0]        idx,             idx_nx;
   logic [4:0]        snap_cmd_st,     snap_cmd_st_nx;
   logic [99:0]       snap_cmd_hist,   snap_cmd_hist_nx;
   logic [7:0]        snap_ready_cnt,  snap_ready_cnt_nx;
   logic [7:0]        snap_error_cnt,  snap_error_cnt_nx;
   logic [3:0]        snap_error_id,   snap_error_id_nx;
   logic [31:0]       snap_error_hist, snap_error_hist_nx;
   logic              stale,           stale_nx;
   logic [7:0]        wcnt,            wcnt_nx;
   logic [WORD_W-1:0] dt,              dt_nx;
   logic              dt_vld,          dt_vld_nx;
   logic              busy,            busy_nx;
   logic              done,            done_nx;

   logic              xfer;
   logic [7:0]        wcnt_inc;
   logic [4:0]        idx_inc;
   logic              drift;

   function automatic logic [WORD_W-1:0] cmd_word(input logic [4:0] i, input logic [99:0] h);
      logic [6:0] b;
      b = 7'(i) * 7'd5;
      return {4'h1, 2'b00, i, h[b +: 5]};
   endfunction

   function automatic logic [WORD_W-1:0] err_word(input logic [3:0] i, input logic [31:0] h);
      logic [4:0] b;
      b = {i[2:0], 2'b00};
      return {4'h2, 4'h0, i, h[b +: 4]};
   endfunction

   function automatic logic [WORD_W-1:0] trl_word(input logic s, input logic [7:0] w);
      return {4'hF, s, 3'b000, w};
   endfunction

   assign xfer     = dt_vld & bus.dt_rdy_i;
   assign wcnt_inc = 8'(wcnt + 8'd1);
   assign idx_inc  = 5'(idx + 5'd1);
   assign drift    = (bus.cmd_st_i != snap_cmd_st) | (bus.error_cnt_i != snap_error_cnt);

   // Next-state, snapshot and next dump word selection
   always_comb begin
      state_nx           = state;
      idx_nx             = idx;
      snap_cmd_st_nx     = snap_cmd_st;
      snap_cmd_hist_nx   = snap_cmd_hist;
      snap_ready_cnt_nx  = snap_ready_cnt;
      snap_error_cnt_nx  = snap_error_cnt;
      snap_error_id_nx   = snap_error_id;
      snap_error_hist_nx = snap_error_hist;
      stale_nx           = stale | (busy & drift);
      wcnt_nx            = wcnt;
      dt_nx              = dt;
      dt_vld_nx          = dt_vld;
      busy_nx            = busy;
      done_nx            = 1'b0;

      case (state)
         IDLE: begin
            if (bus.req_i) begin
               snap_cmd_st_nx     = bus.cmd_st_i;
               snap_cmd_hist_nx   = bus.cmd_hist_i;
               snap_ready_cnt_nx  = bus.ready_cnt_i;
               snap_error_cnt_nx  = bus.error_cnt_i;
               snap_error_id_nx   = bus.error_id_i;
               snap_error_hist_nx = bus.error_hist_i;
               stale_nx           = 1'b0;
               wcnt_nx            = 8'd0;
               idx_nx             = 5'd0;
               state_nx           = HDR0;
               dt_nx              = {4'hD, 3'b000, bus.cmd_st_i, bus.error_id_i};
               dt_vld_nx          = 1'b1;
               busy_nx            = 1'b1;
            end
         end
         HDR0: begin
            if (xfer) begin
               state_nx = HDR1;
               wcnt_nx  = wcnt_inc;
               dt_nx    = {snap_ready_cnt, snap_error_cnt};
            end
         end
         HDR1: begin
            if (xfer) begin
               wcnt_nx = wcnt_inc;
               idx_nx  = 5'd0;
               if (DEBUG != 0) begin
                  state_nx = CMD;
                  dt_nx    = cmd_word(5'd0, snap_cmd_hist);
               end else begin
                  state_nx = TRL;
                  dt_nx    = trl_word(stale_nx, wcnt_inc);
               end
            end
         end
         CMD: begin
            if (xfer) begin
               wcnt_nx = wcnt_inc;
               if (idx == 5'(CMD_N - 1)) begin
                  state_nx = ERR;
                  idx_nx   = 5'd0;
                  dt_nx    = err_word(4'd0, snap_error_hist);
               end else begin
                  idx_nx = idx_inc;
                  dt_nx  = cmd_word(idx_inc, snap_cmd_hist);
               end
            end
         end
         ERR: begin
            if (xfer) begin
               wcnt_nx = wcnt_inc;
               if (idx == 5'(ERR_N - 1)) begin
                  state_nx = TRL;
                  idx_nx   = 5'd0;
                  dt_nx    = trl_word(stale_nx, wcnt_inc);
               end else begin
                  idx_nx = idx_inc;
                  dt_nx  = err_word(idx_inc[3:0], snap_error_hist);
               end
            end
         end
         TRL: begin
            if (xfer) begin
               state_nx  = IDLE;
               dt_vld_nx = 1'b0;
               busy_nx   = 1'b0;
               done_nx   = 1'b1;
            end
         end
         default: begin
            state_nx  = IDLE;
            dt_vld_nx = 1'b0;
            busy_nx   = 1'b0;
         end
      endcase
   end

   // State, snapshot and output registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state           <= IDLE;
         idx             <= 5'd0;
         snap_cmd_st     <= 5'd0;
         snap_cmd_hist   <= 100'd0;
         snap_ready_cnt  <= 8'd0;
         snap_error_cnt  <= 8'd0;
         snap_error_id   <= 4'd0;
         snap_error_hist <= 32'd0;
         stale           <= 1'b0;
         wcnt            <= 8'd0;
         dt              <= '0;
         dt_vld          <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
      end else begin
         state           <= state_nx;
         idx             <= idx_nx;
         snap_cmd_st     <= snap_cmd_st_nx;
         snap_cmd_hist   <= snap_cmd_hist_nx;
         snap_ready_cnt  <= snap_ready_cnt_nx;
         snap_error_cnt  <= snap_error_cnt_nx;
         snap_error_id   <= snap_error_id_nx;
         snap_error_hist <= snap_error_hist_nx;
         stale           <= stale_nx;
         wcnt            <= wcnt_nx;
         dt              <= dt_nx;
         dt_vld          <= dt_vld_nx;
         busy            <= busy_nx;
         done            <= done_nx;
      end
   end

   assign bus.dt_o     = dt;
   assign bus.dt_vld_o = dt_vld;
   assign bus.busy_o   = busy;
   assign bus.done_o   = done;

endmodule
